// File: rtl/seven_segment_capture_if.sv
// Multiplexed seven-segment display bus: segment lines plus one-hot digit enables.
// The display driver owns the master side; capture/monitor logic listens on slave.
interface seven_segment_capture_if #(
   parameter int DIGITS = 4
);
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;

   modport master (output seg, output an);
   modport slave  (input  seg, input  an);
endinterface

// File: rtl/seven_segment_capture.sv
// Recovers BCD digits from a multiplexed seven-segment bus: glitch filter,
// per-digit decode, undecodable-pattern error pulse and once-per-frame pulse.
module seven_segment_capture #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seven_segment_capture_if.slave bus,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     digit_valid,
   output logic                  frame_valid,
   output logic                  err
);

   localparam int         W       = DIGITS + 7;
   localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES);

   logic [W-1:0]      cur;
   logic [W-1:0]      s_reg;
   logic [3:0]        cnt;
   logic [DIGITS-1:0] seen;

   logic              same;
   logic              cap;
   logic              onehot;
   logic [DIGITS-1:0] an_s;
   logic [6:0]        seg_s;
   logic [4:0]        dec;
   logic [DIGITS-1:0] seen_upd;
   logic              frame_hit;

   // {ok, code}; ok=0 marks a pattern outside the digit set
   function automatic logic [4:0] decode(input logic [6:0] s);
      logic [4:0] r;
      r = 5'h00;
      case (s)
         7'h7E: r = {1'b1, 4'h0};
         7'h30: r = {1'b1, 4'h1};
         7'h6D: r = {1'b1, 4'h2};
         7'h79: r = {1'b1, 4'h3};
         7'h33: r = {1'b1, 4'h4};
         7'h5B: r = {1'b1, 4'h5};
         7'h5F: r = {1'b1, 4'h6};
         7'h70: r = {1'b1, 4'h7};
         7'h7F: r = {1'b1, 4'h8};
         7'h7B: r = {1'b1, 4'h9};
         7'h00: r = {1'b1, 4'hF};
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   assign cur   = {bus.an, bus.seg};
   assign same  = (cur == s_reg);
   // fires only on the STABLE_CYCLES-1 -> STABLE_CYCLES step, so a steady bus captures once
   assign cap   = same && (cnt == CNT_MAX - 4'd1);
   assign an_s  = s_reg[W-1:7];
   assign seg_s = s_reg[6:0];
   assign dec   = decode(seg_s);
   assign onehot    = ($countones(an_s) == 1);
   assign seen_upd  = seen | an_s;
   assign frame_hit = (seen_upd == {DIGITS{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_reg       <= '0;
         cnt         <= '0;
         seen        <= '0;
         digits      <= '0;
         digit_valid <= '0;
         frame_valid <= 1'b0;
         err         <= 1'b0;
      end else begin
         s_reg       <= cur;
         frame_valid <= 1'b0;
         err         <= 1'b0;
         if (!same)
            cnt <= '0;
         else if (cnt != CNT_MAX)
            cnt <= cnt + 4'd1;

         // zero or multi-hot enables are inter-digit blanking and are ignored
         if (cap && onehot) begin
            if (dec[4]) begin
               for (int i = 0; i < DIGITS; i++)
                  if (an_s[i]) digits[4*i +: 4] <= dec[3:0];
               digit_valid <= digit_valid | an_s;
               if (frame_hit) begin
                  frame_valid <= 1'b1;
                  seen        <= '0;
               end else begin
                  seen <= seen_upd;
               end
            end else begin
               digit_valid <= digit_valid & ~an_s;
               err         <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture (DIGITS=4, STABLE_CYCLES=4).
module tb_seven_segment_capture;

   logic        clk;
   logic        rst_n;
   logic [15:0] digits;
   logic [3:0]  digit_valid;
   logic        frame_valid;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;
   int fv_cnt = 0;
   int err_cnt = 0;

   seven_segment_capture_if #(.DIGITS(4)) bus ();

   seven_segment_capture #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.slave),
      .digits      (digits),
      .digit_valid (digit_valid),
      .frame_valid (frame_valid),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // pulses counted at the following rising edge, so a stuck-high pulse counts more than once
   always @(posedge clk) begin
      if (frame_valid === 1'b1) fv_cnt++;
      if (err === 1'b1) err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s);
      bus.an  = a;
      bus.seg = s;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(4'b0000, 7'h00);
      step(3);
      chk("reset_digits", 32'(digits), 32'h0);
      chk("reset_valid", 32'(digit_valid), 32'h0);
      chk("reset_fv_err", {30'b0, frame_valid, err}, 32'h0);
      rst_n = 1'b1;
      step(6);

      // single capture, plus the edge just before it
      drive(4'b0001, 7'h79);
      step(4);
      chk("cap_early_valid", 32'(digit_valid), 32'h0);
      step(1);
      chk("cap_digit0", 32'(digits[3:0]), 32'h3);
      chk("cap_valid", 32'(digit_valid), 32'h1);
      drive(4'b0000, 7'h00);
      step(6);
      chk("cap_no_pulses", {fv_cnt[15:0], err_cnt[15:0]}, 32'h0);

      // glitch reject: 3-edge run of "1" must not capture
      drive(4'b0010, 7'h30);
      step(3);
      drive(4'b0010, 7'h33);
      step(4);
      chk("glitch_pending", 32'(digit_valid), 32'h1);
      chk("glitch_digits", 32'(digits), 32'h0003);
      step(1);
      chk("glitch_digit1", 32'(digits[7:4]), 32'h4);
      chk("glitch_valid", 32'(digit_valid), 32'h3);
      drive(4'b0000, 7'h00);
      step(6);

      // full frame 0,1,2,8
      drive(4'b0001, 7'h7E); step(6); drive(4'b0000, 7'h00); step(6);
      drive(4'b0010, 7'h30); step(6); drive(4'b0000, 7'h00); step(6);
      drive(4'b0100, 7'h6D); step(6); drive(4'b0000, 7'h00); step(6);
      chk("frame_none_yet", 32'(fv_cnt), 32'd0);
      drive(4'b1000, 7'h7F);
      step(5);
      chk("frame_pulse", 32'(frame_valid), 32'h1);
      chk("frame_digits", 32'(digits), 32'h8210);
      chk("frame_valid_all", 32'(digit_valid), 32'hF);
      step(1);
      chk("frame_pulse_end", 32'(frame_valid), 32'h0);
      drive(4'b0000, 7'h00);
      step(6);
      chk("frame_one_pulse", 32'(fv_cnt), 32'd1);

      // error: digit 2 holds 7, then an undecodable pattern
      drive(4'b0100, 7'h70); step(6); drive(4'b0000, 7'h00); step(6);
      chk("err_pre_digit2", 32'(digits), 32'h8710);
      drive(4'b0100, 7'h01);
      step(5);
      chk("err_pulse", 32'(err), 32'h1);
      chk("err_valid_clr", 32'(digit_valid), 32'hB);
      chk("err_digit_kept", 32'(digits[11:8]), 32'h7);
      step(1);
      chk("err_pulse_end", 32'(err), 32'h0);
      drive(4'b0110, 7'h01);
      step(10);
      chk("multihot_err_cnt", 32'(err_cnt), 32'd1);
      chk("multihot_valid", 32'(digit_valid), 32'hB);
      chk("multihot_digits", 32'(digits), 32'h8710);
      drive(4'b0000, 7'h00);
      step(6);

      // blank decodes to F; long hold captures once
      drive(4'b0001, 7'h00);
      step(5);
      chk("blank_digit0", 32'(digits), 32'h871F);
      chk("blank_valid", 32'(digit_valid), 32'hB);
      step(20);
      chk("hold_no_repeat", {fv_cnt[15:0], err_cnt[15:0]}, {16'd1, 16'd1});
      chk("hold_digits", 32'(digits), 32'h871F);

      // async reset mid-run, then capture restarts from the first post-reset sample
      drive(4'b0001, 7'h30);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_digits", 32'(digits), 32'h0);
      chk("async_rst_valid", 32'(digit_valid), 32'h0);
      chk("async_rst_fv_err", {30'b0, frame_valid, err}, 32'h0);
      step(2);
      rst_n = 1'b1;
      step(4);
      chk("post_rst_pending", 32'(digit_valid), 32'h0);
      step(1);
      chk("post_rst_cap", 32'(digits), 32'h0001);
      chk("post_rst_valid", 32'(digit_valid), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
